// File: rtl/if_stage_pkg.sv
// Shared front-end definitions: pipeline stage codes, fetch FSM encodings
// and the queue entry layout used by the instruction fetch stage.
package if_stage_pkg;

    localparam logic [2:0] STAGE_IF  = 3'd0;
    localparam logic [2:0] STAGE_ID  = 3'd1;
    localparam logic [2:0] STAGE_EX  = 3'd2;
    localparam logic [2:0] STAGE_MEM = 3'd3;
    localparam logic [2:0] STAGE_WB  = 3'd4;

    localparam logic [0:0] IF_RUN   = 1'b0;
    localparam logic [0:0] IF_FLUSH = 1'b1;

    localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } if_entry_t;

    // Advance a word address by one instruction; wraps naturally at the top of memory.
    function automatic logic [29:0] next_word(input logic [29:0] word);
        return word + 30'd1;
    endfunction

endpackage

// File: rtl/if_queue.sv
// Circular instruction FIFO between the ROM response and the decoder.
// Flush has priority over push and pop in the same cycle.
module if_queue
    import if_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  if_entry_t                        push_entry_i,
    input  logic                             pop_i,
    input  logic                             flush_i,
    output if_entry_t                        head_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [$clog2(DEPTH + 1) - 1:0]   count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word reads to a synchronous ROM, buffers the
// responses in a small queue and presents them to decode with a valid/ready handshake.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic        rom_en,
    output logic [29:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    logic [0:0]  state_q, state_d;
    logic [29:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [29:0] inflight_pc_q, inflight_pc_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [OccW-1:0] occ_after;
    logic [CntW-1:0] q_count;
    logic            q_empty;
    if_entry_t       q_head;
    if_entry_t       push_entry;

    logic unused_q_full;
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign pop       = inst_valid & inst_ready;
    assign occ_after = OccW'(q_count) + OccW'(inflight_q) - OccW'(pop);
    // Reset gating keeps the strobe low while reset is held.
    assign issue     = reset_n & en & (occ_after < OccW'(DEPTH));

    // The only response that can land in FLUSH is one issued before the redirect.
    assign push       = inflight_q & (state_q == IF_RUN);
    assign push_entry = '{pc: {inflight_pc_q, 2'b00}, data: rom_data};

    always_comb begin
        state_d       = redirect_valid ? IF_FLUSH : IF_RUN;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = next_word(fetch_pc_q);
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc[31:2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IF_RUN;
            fetch_pc_q    <= RESET_PC[31:2];
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    if_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_o       (q_head),
        .full_o       (unused_q_full),
        .empty_o      (q_empty),
        .count_o      (q_count)
    );

    assign rom_en     = issue;
    assign rom_addr   = fetch_pc_q;
    assign inst_valid = ~q_empty;
    assign inst_data  = inst_valid ? q_head.data : '0;
    assign inst_pc    = inst_valid ? q_head.pc : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a behavioural synchronous ROM holding addr+100.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        rom_en;
    logic [29:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= {2'b00, rom_addr} + 32'd100;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; en = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) tick();
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
        checks++; if (rom_addr !== 30'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", inst_data); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
    endtask

    task automatic test_stream();
        reset_n = 1'b1;
        #1;
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL stream_first_issue: got %b want 1", rom_en); end
        checks++; if (rom_addr !== 30'h0) begin errors++; $display("FAIL stream_first_addr: got %h want 0", rom_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid: got %b want 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %b want 0", inst_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, inst_pc, 32'(4 * k)); end
            checks++; if (inst_data !== 32'(100 + k)) begin errors++; $display("FAIL stream_data[%0d]: got %0d want %0d", k, inst_data, 100 + k); end
            if (k < 2) tick();
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL bp_stop_issue: got %b want 0", rom_en); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'd102) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h d=%0d want v=1 pc=8 d=102", i, inst_valid, inst_pc, inst_data);
            end
            checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: got rom_en %b want 0", i, rom_en); end
        end
        inst_ready = 1'b1;
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h4) begin
            errors++; $display("FAIL bp_resume: got en=%b addr=%h want en=1 addr=4", rom_en, rom_addr);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(8 + 4 * k) || inst_data !== 32'(102 + k)) begin
                errors++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h d=%0d want v=1 pc=%h d=%0d", k, inst_valid, inst_pc, inst_data, 8 + 4 * k, 102 + k);
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_flush_valid: got %b want 0", inst_valid); end
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h10) begin
            errors++; $display("FAIL rd_refetch: got en=%b addr=%h want en=1 addr=10", rom_en, rom_addr);
        end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_stale: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'd116) begin
            errors++; $display("FAIL rd_target: got v=%b pc=%h d=%0d want v=1 pc=40 d=116", inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h44 || inst_data !== 32'd117) begin
            errors++; $display("FAIL rd_next: got v=%b pc=%h d=%0d want v=1 pc=44 d=117", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h3FFF_FFFF) begin
            errors++; $display("FAIL wrap_top_addr: got en=%b addr=%h want en=1 addr=3fffffff", rom_en, rom_addr);
        end
        tick();
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h0) begin
            errors++; $display("FAIL wrap_zero_addr: got en=%b addr=%h want en=1 addr=0", rom_en, rom_addr);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h4000_0063) begin
            errors++; $display("FAIL wrap_top_inst: got v=%b pc=%h d=%h want v=1 pc=fffffffc d=40000063", inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'd100) begin
            errors++; $display("FAIL wrap_zero_inst: got v=%b pc=%h d=%0d want v=1 pc=0 d=100", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_redirect_handshake();
        apply_reset();
        repeat (4) tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
            errors++; $display("FAIL rh_head: got v=%b pc=%h want v=1 pc=8", inst_valid, inst_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_flush1: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_flush2: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'd164) begin
            errors++; $display("FAIL rh_target: got v=%b pc=%h d=%0d want v=1 pc=100 d=164", inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || inst_data !== 32'd165) begin
            errors++; $display("FAIL rh_next: got v=%b pc=%h d=%0d want v=1 pc=104 d=165", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_reset_midflight();
        reset_n = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin
            errors++; $display("FAIL rm_immediate: got v=%b rom_en=%b want 0 0", inst_valid, rom_en);
        end
        checks++; if (inst_pc !== 32'h0 || rom_addr !== 30'h0) begin
            errors++; $display("FAIL rm_values: got pc=%h addr=%h want 0 0", inst_pc, rom_addr);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h0) begin
            errors++; $display("FAIL rm_restart: got en=%b addr=%h want en=1 addr=0", rom_en, rom_addr);
        end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'd100) begin
            errors++; $display("FAIL rm_first: got v=%b pc=%h d=%0d want v=1 pc=0 d=100", inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'd101) begin
            errors++; $display("FAIL rm_second: got v=%b pc=%h d=%0d want v=1 pc=4 d=101", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_en_low();
        en = 1'b0;
        #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL en_block: got %b want 0", rom_en); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'd102) begin
            errors++; $display("FAIL en_inflight: got v=%b pc=%h d=%0d want v=1 pc=8 d=102", inst_valid, inst_pc, inst_data);
        end
        repeat (2) tick();
        checks++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin
            errors++; $display("FAIL en_idle: got v=%b rom_en=%b want 0 0", inst_valid, rom_en);
        end
        en = 1'b1;
        #1;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 30'h3) begin
            errors++; $display("FAIL en_resume: got en=%b addr=%h want en=1 addr=3", rom_en, rom_addr);
        end
        repeat (2) tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst_data !== 32'd103) begin
            errors++; $display("FAIL en_next: got v=%b pc=%h d=%0d want v=1 pc=c d=103", inst_valid, inst_pc, inst_data);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_wrap();
        test_redirect_handshake();
        test_reset_midflight();
        test_en_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2, instruction queue entries (legal 2..4).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  fetch enable; low blocks new ROM requests only.
REQ-006 rom_en  output  1  synchronous ROM read strobe.
REQ-007 rom_addr  output  30  ROM word address, equal to fetch_pc[31:2].
REQ-008 rom_data  input  32  ROM read data, valid exactly one cycle after rom_en.
REQ-009 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-011 inst_valid  output  1  queue head holds a valid instruction.
REQ-012 inst_ready  input  1  decoder accepts head this cycle.
REQ-013 inst_data  output  32  instruction word at queue head.
REQ-014 inst_pc  output  32  byte address of inst_data (PC_Add_4 = inst_pc + 4 is derived by the consumer).

Function
REQ-015 Handshake: transfer occurs when inst_valid and inst_ready are both high at a rising edge; inst_data/inst_pc hold stable while inst_valid is high and inst_ready is low.
REQ-016 Issue: rom_en SHALL be high when en=1, state is RUN or FLUSH, and (queue occupancy + in-flight count - pop this cycle) < DEPTH; fetch_pc advances by 4 on each issue, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-017 At most one request in flight; in-flight pc is captured with each issue.
REQ-018 Response: in the cycle after an issue, rom_data with the captured pc SHALL be written to the queue tail unless squashed; inst_valid for it rises the following cycle (issue-to-valid latency 2 cycles).
REQ-019 Queue SHALL be a circular FIFO; push to a full queue SHALL never occur (guaranteed by REQ-016); simultaneous push and pop on a full or empty queue SHALL both take effect.
REQ-020 FSM states RUN and FLUSH; RUN -> FLUSH on redirect_valid; FLUSH -> RUN unconditionally after one cycle; redirect_valid in FLUSH re-enters FLUSH with the newer pc.
REQ-021 Redirect at edge: queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}, any in-flight response marked squashed; inst_valid low the next cycle.
REQ-022 In FLUSH, returning rom_data SHALL be discarded and a new request at fetch_pc MAY issue; first redirected instruction valid 3 cycles after redirect_valid.
REQ-023 Redirect coinciding with a handshake: the handshake completes (head consumed) and then the flush applies.
REQ-024 en low: no new issues; an in-flight response is still captured; handshake continues; fetch_pc held.

Reset
REQ-025 On reset_n low, immediately: state RUN, fetch_pc = RESET_PC, queue empty, in-flight cleared, squash cleared.
REQ-026 Output reset values: rom_en 0, rom_addr RESET_PC[31:2], inst_valid 0, inst_data 0, inst_pc 0.
REQ-027 Reset asserted mid-request discards that request; the first request after release is at RESET_PC in the first cycle with en=1.

Structure
REQ-028 FSM state encodings (IF_RUN, IF_FLUSH) and the default RESET_PC value SHALL live in the shared defines file alongside the existing stage codes.
REQ-029 The queue SHALL be one sub-module, if_queue (parameter DEPTH, 32-bit data + 32-bit pc, push/pop/flush, full/empty/count).
REQ-030 rom_addr SHALL drive the existing synchronous ROM's address port directly.

Verification
REQ-031 Reset release, en=1, inst_ready=1, ROM[i]=i+100 -> inst_valid at cycle 2, inst_pc 0,4,8 with data 100,101,102 on consecutive cycles.
REQ-032 inst_ready=0 for 10 cycles -> exactly DEPTH entries buffered, rom_en low once full, data held stable; releasing ready drains in order with no gaps or duplicates.
REQ-033 redirect_valid with redirect_pc=32'h0000_0043 while a request is in flight -> stale word never appears; next inst_pc = 32'h40 three cycles later.
REQ-034 redirect_valid in same cycle as handshake of pc 0x8 -> 0x8 consumed once, queue flushed, refetch from redirect target.
REQ-035 fetch_pc = 32'hFFFF_FFFC -> next issue rom_addr = 0, inst_pc sequence FFFF_FFFC, 0000_0000.
REQ-036 reset_n pulsed low while a response is due -> inst_valid 0 immediately, fetch restarts at RESET_PC, no stale entry.
